instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
- Responder end of the instruction-memory req/grant/rvalid handshake that the fetch stage initiates and the IF trace logic observes.
- Word-organised behavioural instruction memory with parameterised grant and read latencies, a bounded in-order outstanding-request queue, and a backdoor load port.
- Used as the instruction-side memory in trace test benches, so grant and rvalid timing is deterministic and cycle-exact.

Parameters:
- ADDR_WIDTH, 32, width of instr_addr and load_addr.
- DATA_WIDTH, 32, width of instr_rdata and load_data.
- MEM_DEPTH, 1024, number of DATA_WIDTH words; power of two.
- GNT_LATENCY, 0, number of consecutive req-high cycles before grant is allowed; 0 gives same-cycle grant.
- RVALID_LATENCY, 1, cycles from grant to rvalid; must be at least 1.
- MAX_OUTSTANDING, 2, maximum granted but unreturned requests; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr_req  in  1  request; held high until granted.
- instr_addr  in  ADDR_WIDTH  byte address; sampled in the grant cycle.
- instr_grant  out  1  request accepted this cycle.
- instr_rvalid  out  1  one-cycle pulse; instr_rdata is valid.
- instr_rdata  out  DATA_WIDTH  read data.
- stall  in  1  forces instr_grant low while high.
- load_en  in  1  backdoor write enable.
- load_addr  in  ADDR_WIDTH  backdoor word index (not a byte address).
- load_data  in  DATA_WIDTH  backdoor write data.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  count of granted requests not yet returned.
- access_err  out  1  pulses with instr_rvalid when the returned access was out of range.
- protocol_err  out  1  sticky; set when instr_req drops before grant.

Behaviour:
- Reset (rst low, asynchronous):
  - instr_grant, instr_rvalid, access_err, protocol_err, outstanding_o and instr_rdata go to 0.
  - Response queue is flushed; in-flight requests are dropped and never return rvalid.
  - Grant FSM returns to IDLE.
  - Memory contents are not cleared.
- Address decode:
  - index = instr_addr[ADDR_WIDTH-1:2]; bits [1:0] are ignored.
  - In range iff index < MEM_DEPTH. An out-of-range access returns rdata 0 with access_err=1.
- Eligibility: (outstanding_o - instr_rvalid) < MAX_OUTSTANDING && !stall. A slot retiring in the current cycle may be reused in that same cycle.
- Grant FSM, states IDLE and WAIT:
  - IDLE, GNT_LATENCY=0: instr_grant = instr_req && eligible, combinational in the same cycle.
  - IDLE, GNT_LATENCY>0: on instr_req, go to WAIT with wait counter = GNT_LATENCY-1.
  - WAIT: counter decrements each cycle. Grant is asserted in the cycle req has been high for GNT_LATENCY prior consecutive cycles and eligible. If not eligible, hold in WAIT and grant at the first eligible cycle.
  - After grant: if req is still high next cycle, a new request starts (IDLE semantics, counter reloaded); otherwise go to IDLE.
  - instr_req low while in WAIT: set protocol_err (sticky until reset) and go to IDLE.
- Response path:
  - Grant at cycle t: memory is read at t and the entry {data, err, countdown=RVALID_LATENCY} is enqueued.
  - instr_rvalid=1 exactly at t+RVALID_LATENCY. Returns are in order.
  - instr_rdata and access_err update only on rvalid cycles; instr_rdata otherwise holds its last value.
- outstanding_o: +1 on grant, -1 on rvalid, net 0 when both occur in the same cycle. It never exceeds MAX_OUTSTANDING.
- Back-to-back grants are possible every cycle when GNT_LATENCY=0 and eligibility allows.
- Backdoor load:
  - mem[load_addr] = load_data on clk when load_en.
  - If the load targets the index read by a same-cycle grant, the read returns the old data (read-before-write).
  - Out-of-range load_addr is ignored.

Test Plan:
- GNT_LATENCY=0, RVALID_LATENCY=1: load mem[4]=0xDEADBEEF; req addr 0x10 at cycle 0 -> grant at cycle 0; rvalid at cycle 1 with rdata 0xDEADBEEF, access_err 0; outstanding_o 1 then 0.
- GNT_LATENCY=2: req held from cycle 0 -> grant only at cycle 2, rvalid at cycle 3; grant is low in cycles 0-1.
- MAX_OUTSTANDING=2, RVALID_LATENCY=3: req held with addrs 0x0/0x4/0x8 -> grants at cycles 0 and 1, none at 2, third grant at 3 together with the first rvalid; rvalids at cycles 3, 4, 6 in order.
- MEM_DEPTH=1024: req addr 0x0001_0000 -> rvalid with rdata 0x0 and access_err=1 for exactly one cycle.
- Grant at cycle 0, RVALID_LATENCY=2, rst low at cycle 1 -> no rvalid at cycle 2; outstanding_o 0; next req after reset is served normally.
- GNT_LATENCY=3: req high for cycles 0-1, low at cycle 2 -> no grant; protocol_err=1 and stays 1 through later transactions until reset.

Source files
------------

// File: rtl/instr_mem_responder.sv
// -----------------------------------------------------------------------------
// instr_mem_responder
//
// Responder side of the instruction-fetch req/grant/rvalid handshake. Holds a
// word-organised instruction memory that can be filled through a backdoor
// load port, grants requests after a configurable number of req-high cycles,
// and returns read data a fixed number of cycles after each grant, in order.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   instr_req      fetch request, held high until granted
//   instr_addr     byte address, sampled in the grant cycle
//   instr_grant    request accepted this cycle
//   instr_rvalid   one-cycle pulse, instr_rdata valid
//   instr_rdata    read data (holds between returns)
//   stall          forces instr_grant low while high
//   load_en        backdoor write enable
//   load_addr      backdoor word index
//   load_data      backdoor write data
//   outstanding_o  granted requests not yet returned
//   access_err     pulses with instr_rvalid for an out-of-range access
//   protocol_err   sticky, set when instr_req drops before being granted
// -----------------------------------------------------------------------------
module instr_mem_responder #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MEM_DEPTH       = 1024,
    parameter int GNT_LATENCY     = 0,
    parameter int RVALID_LATENCY  = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     instr_req,
    input  logic [ADDR_WIDTH-1:0]                    instr_addr,
    output logic                                     instr_grant,
    output logic                                     instr_rvalid,
    output logic [DATA_WIDTH-1:0]                    instr_rdata,
    input  logic                                     stall,
    input  logic                                     load_en,
    input  logic [ADDR_WIDTH-1:0]                    load_addr,
    input  logic [DATA_WIDTH-1:0]                    load_data,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
    output logic                                     access_err,
    output logic                                     protocol_err
);

    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int RL     = RVALID_LATENCY;
    // The wait counter only ever holds GNT_LATENCY-1 down to 0.
    localparam int CNT_W  = (GNT_LATENCY > 1) ? $clog2(GNT_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (GNT_LATENCY > 0) ? CNT_W'(GNT_LATENCY - 1) : '0;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    // ------------------------------------------------------------------
    // Address decode and memory
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-3:0] rd_index;
    logic                  rd_in_range;
    logic                  load_in_range;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  unused_addr_bits;

    assign rd_index         = instr_addr[ADDR_WIDTH-1:2];
    assign rd_in_range      = (rd_index < (ADDR_WIDTH-2)'(MEM_DEPTH));
    assign load_in_range    = (load_addr < ADDR_WIDTH'(MEM_DEPTH));
    assign unused_addr_bits = ^instr_addr[1:0];

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Contents survive reset so a preloaded program stays in place.
    always_ff @(posedge clk) begin
        if (load_en && load_in_range) begin
            mem_q[load_addr[MEM_AW-1:0]] <= load_data;
        end
    end

    // Read sampled in the grant cycle; a same-cycle load lands at the edge,
    // so the grant sees the old word.
    assign rd_data = rd_in_range ? mem_q[rd_index[MEM_AW-1:0]] : '0;

    // ------------------------------------------------------------------
    // Eligibility and grant
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] outstanding_q;
    logic             eligible;
    logic             grant_now;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             perr_q;

    // A slot retiring this cycle may be handed straight to a new grant.
    assign eligible = ((outstanding_q - OUT_W'(instr_rvalid)) < OUT_W'(MAX_OUTSTANDING)) && !stall;

    always_comb begin
        grant_now = 1'b0;
        if (rst && instr_req && eligible) begin
            if (state_q == S_IDLE) begin
                grant_now = (GNT_LATENCY == 0);
            end else begin
                grant_now = (cnt_q == '0);
            end
        end
    end

    // A request that is not granted on its first cycle waits in S_WAIT,
    // even with zero latency, so a later drop of req is seen as a
    // protocol violation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (instr_req && !grant_now) begin
                        state_q <= S_WAIT;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (!instr_req) begin
                        perr_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (grant_now) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_q + OUT_W'(grant_now) - OUT_W'(instr_rvalid);
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline: every entry ages at the same rate, so a fixed
    // shift line keeps returns in order and exactly RL cycles after grant.
    // The last stage is the output register and only updates data on a
    // valid return.
    // ------------------------------------------------------------------
    logic [RL-1:0]         vld_q;
    logic [RL-1:0]         err_q;
    logic [DATA_WIDTH-1:0] data_q [RL];
    logic [RL-1:0]         src_vld;
    logic [RL-1:0]         src_err;
    logic [DATA_WIDTH-1:0] src_data [RL];

    assign src_vld[0]  = grant_now;
    assign src_err[0]  = !rd_in_range;
    assign src_data[0] = rd_data;

    generate
        for (genvar gi = 1; gi < RL; gi++) begin : g_stage
            assign src_vld[gi]  = vld_q[gi-1];
            assign src_err[gi]  = err_q[gi-1];
            assign src_data[gi] = data_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            err_q <= '0;
            for (int k = 0; k < RL; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            vld_q <= src_vld;
            for (int k = 0; k < RL - 1; k++) begin
                data_q[k] <= src_data[k];
                err_q[k]  <= src_err[k];
            end
            err_q[RL-1] <= src_vld[RL-1] & src_err[RL-1];
            if (src_vld[RL-1]) begin
                data_q[RL-1] <= src_data[RL-1];
            end
        end
    end

    assign instr_grant   = grant_now;
    assign instr_rvalid  = vld_q[RL-1];
    assign instr_rdata   = data_q[RL-1];
    assign access_err    = err_q[RL-1];
    assign outstanding_o = outstanding_q;
    assign protocol_err  = perr_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_responder
//
// Three responder instances with different latency / outstanding settings
// share one backdoor load bus. A transaction-level model (per-request age,
// a queue of due cycles, a word array) predicts every output each cycle; a
// few directed sequences pin literal values, then random traffic follows.
// -----------------------------------------------------------------------------
module tb_instr_mem_responder;

    localparam int N     = 3;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int MAW   = 10;

    localparam int G0 = 0, R0 = 1, M0 = 2;
    localparam int G1 = 2, R1 = 2, M1 = 1;
    localparam int G2 = 0, R2 = 3, M2 = 2;

    function automatic int p_g(input int i);
        return (i == 0) ? G0 : (i == 1) ? G1 : G2;
    endfunction
    function automatic int p_r(input int i);
        return (i == 0) ? R0 : (i == 1) ? R1 : R2;
    endfunction
    function automatic int p_m(input int i);
        return (i == 0) ? M0 : (i == 1) ? M1 : M2;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT inputs
    logic          rst_n;
    logic          req   [N];
    logic [AW-1:0] addr  [N];
    logic          stall [N];
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;

    // DUT outputs
    logic          gnt   [N];
    logic          rv    [N];
    logic [DW-1:0] rdata [N];
    logic          aerr  [N];
    logic          perr  [N];
    logic [1:0]    outs0;
    logic [0:0]    outs1;
    logic [1:0]    outs2;

    // Inputs to apply on the next cycle
    logic          nx_rst;
    logic          nx_req   [N];
    logic [AW-1:0] nx_addr  [N];
    logic          nx_stall [N];
    logic          nx_load_en;
    logic [AW-1:0] nx_load_addr;
    logic [DW-1:0] nx_load_data;

    instr_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
                          .GNT_LATENCY(G0), .RVALID_LATENCY(R0), .MAX_OUTSTANDING(M0)) u_dut0 (
        .clk(clk), .rst(rst_n), .instr_req(req[0]), .instr_addr(addr[0]),
        .instr_grant(gnt[0]), .instr_rvalid(rv[0]), .instr_rdata(rdata[0]),
        .stall(stall[0]), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .outstanding_o(outs0), .access_err(aerr[0]), .protocol_err(perr[0]));

    instr_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
                          .GNT_LATENCY(G1), .RVALID_LATENCY(R1), .MAX_OUTSTANDING(M1)) u_dut1 (
        .clk(clk), .rst(rst_n), .instr_req(req[1]), .instr_addr(addr[1]),
        .instr_grant(gnt[1]), .instr_rvalid(rv[1]), .instr_rdata(rdata[1]),
        .stall(stall[1]), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .outstanding_o(outs1), .access_err(aerr[1]), .protocol_err(perr[1]));

    instr_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
                          .GNT_LATENCY(G2), .RVALID_LATENCY(R2), .MAX_OUTSTANDING(M2)) u_dut2 (
        .clk(clk), .rst(rst_n), .instr_req(req[2]), .instr_addr(addr[2]),
        .instr_grant(gnt[2]), .instr_rvalid(rv[2]), .instr_rdata(rdata[2]),
        .stall(stall[2]), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .outstanding_o(outs2), .access_err(aerr[2]), .protocol_err(perr[2]));

    function automatic int act_outs(input int i);
        return (i == 0) ? int'(outs0) : (i == 1) ? int'(outs1) : int'(outs2);
    endfunction

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    int            cyc;
    int            n_vec;
    int            n_err;
    logic [DW-1:0] mem_m [DEPTH];
    int            q_due [N][8];
    logic [DW-1:0] q_dat [N][8];
    bit            q_err [N][8];
    int            q_hd  [N];
    int            q_cnt [N];
    int            m_outs   [N];
    bit            m_active [N];
    int            m_age    [N];
    bit            m_perr   [N];
    logic [DW-1:0] m_rdata  [N];
    bit            m_gnt    [N];

    // Directed expectations for the three-deep outstanding sequence.
    int            d3_g   [7] = '{1, 1, 0, 1, 0, 0, 0};
    int            d3_v   [7] = '{0, 0, 0, 1, 1, 0, 1};
    int            d3_o   [7] = '{0, 1, 2, 2, 2, 1, 1};
    logic [DW-1:0] d3_dat [7] = '{32'h0, 32'h0, 32'h0, 32'hC0DE0000,
                                  32'hC0DE0001, 32'hC0DE0001, 32'hC0DE0002};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        q_hd[i]     = 0;
        q_cnt[i]    = 0;
        m_outs[i]   = 0;
        m_active[i] = 1'b0;
        m_age[i]    = 0;
        m_perr[i]   = 1'b0;
        m_rdata[i]  = '0;
        m_gnt[i]    = 1'b0;
    endtask

    // Predict and check one instance for the current cycle, then advance.
    task automatic model_step(input int i);
        bit            r;
        bit            el;
        bit            g;
        int            hd;
        int            slot;
        int unsigned   idx;
        logic [DW-1:0] exp_rdata;
        bit            exp_aerr;
        if (!rst_n) begin
            chk($sformatf("rst_grant%0d", i), 32'(gnt[i]), 32'h0);
            chk($sformatf("rst_rvalid%0d", i), 32'(rv[i]), 32'h0);
            chk($sformatf("rst_rdata%0d", i), rdata[i], 32'h0);
            chk($sformatf("rst_aerr%0d", i), 32'(aerr[i]), 32'h0);
            chk($sformatf("rst_outs%0d", i), 32'(act_outs(i)), 32'h0);
            chk($sformatf("rst_perr%0d", i), 32'(perr[i]), 32'h0);
            model_reset(i);
            return;
        end
        hd = q_hd[i];
        r  = (q_cnt[i] > 0) && (q_due[i][hd] == cyc);
        el = ((m_outs[i] - int'(r)) < p_m(i)) && !stall[i];
        g  = req[i] && ((m_active[i] ? m_age[i] : 0) >= p_g(i)) && el;
        exp_rdata = r ? q_dat[i][hd] : m_rdata[i];
        exp_aerr  = r && q_err[i][hd];
        chk($sformatf("grant%0d", i), 32'(gnt[i]), 32'(g));
        chk($sformatf("rvalid%0d", i), 32'(rv[i]), 32'(r));
        chk($sformatf("rdata%0d", i), rdata[i], exp_rdata);
        chk($sformatf("aerr%0d", i), 32'(aerr[i]), 32'(exp_aerr));
        chk($sformatf("outs%0d", i), 32'(act_outs(i)), 32'(m_outs[i]));
        chk($sformatf("perr%0d", i), 32'(perr[i]), 32'(m_perr[i]));
        if (r) begin
            m_rdata[i] = q_dat[i][hd];
            q_hd[i]    = (hd + 1) % 8;
            q_cnt[i]--;
        end
        if (g) begin
            slot = (q_hd[i] + q_cnt[i]) % 8;
            idx  = 32'(addr[i][AW-1:2]);
            q_due[i][slot] = cyc + p_r(i);
            q_dat[i][slot] = (idx < DEPTH) ? mem_m[addr[i][MAW+1:2]] : '0;
            q_err[i][slot] = (idx >= DEPTH);
            q_cnt[i]++;
        end
        m_outs[i] = m_outs[i] + int'(g) - int'(r);
        if (!req[i]) begin
            if (m_active[i]) m_perr[i] = 1'b1;
            m_active[i] = 1'b0;
            m_age[i]    = 0;
        end else if (g) begin
            m_active[i] = 1'b0;
            m_age[i]    = 0;
        end else if (m_active[i]) begin
            m_age[i]++;
        end else begin
            m_active[i] = 1'b1;
            m_age[i]    = 1;
        end
        m_gnt[i] = g;
    endtask

    // One clock: apply staged inputs after the edge, check at the falling edge.
    task automatic step_cycle();
        @(posedge clk);
        #1;
        rst_n     = nx_rst;
        load_en   = nx_load_en;
        load_addr = nx_load_addr;
        load_data = nx_load_data;
        for (int i = 0; i < N; i++) begin
            req[i]   = nx_req[i];
            addr[i]  = nx_addr[i];
            stall[i] = nx_stall[i];
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) model_step(i);
        if (load_en && load_addr < DEPTH) mem_m[load_addr[MAW-1:0]] = load_data;
        cyc++;
    endtask

    initial begin
        int ng;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b0;
        nx_rst = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        nx_load_en = 1'b0; nx_load_addr = '0; nx_load_data = '0;
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b0; addr[i] = '0; stall[i] = 1'b0;
            nx_req[i] = 1'b0; nx_addr[i] = '0; nx_stall[i] = 1'b0;
            model_reset(i);
        end
        for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;

        repeat (2) step_cycle();
        nx_rst = 1'b1;

        // Preload mem[k] = {C0DE, k}
        for (int k = 0; k < DEPTH; k++) begin
            nx_load_en   = 1'b1;
            nx_load_addr = k;
            nx_load_data = {16'hC0DE, k[15:0]};
            step_cycle();
        end
        nx_load_en = 1'b0;
        step_cycle();

        // Same-cycle grant, one-cycle return of a freshly loaded word.
        nx_load_en = 1'b1; nx_load_addr = 4; nx_load_data = 32'hDEADBEEF;
        step_cycle();
        nx_load_en = 1'b0;
        nx_req[0] = 1'b1; nx_addr[0] = 32'h10;
        step_cycle();
        chk("d1_grant", 32'(gnt[0]), 32'h1);
        chk("d1_outs_c0", 32'(outs0), 32'h0);
        nx_req[0] = 1'b0;
        step_cycle();
        chk("d1_rvalid", 32'(rv[0]), 32'h1);
        chk("d1_rdata", rdata[0], 32'hDEADBEEF);
        chk("d1_aerr", 32'(aerr[0]), 32'h0);
        chk("d1_outs_c1", 32'(outs0), 32'h1);
        step_cycle();
        chk("d1_outs_c2", 32'(outs0), 32'h0);
        chk("d1_rdata_hold", rdata[0], 32'hDEADBEEF);

        // Out-of-range access.
        nx_req[0] = 1'b1; nx_addr[0] = 32'h0001_0000;
        step_cycle();
        nx_req[0] = 1'b0;
        step_cycle();
        chk("d4_rvalid", 32'(rv[0]), 32'h1);
        chk("d4_rdata", rdata[0], 32'h0);
        chk("d4_aerr", 32'(aerr[0]), 32'h1);
        step_cycle();
        chk("d4_aerr_drop", 32'(aerr[0]), 32'h0);

        // Grant latency 2, return latency 2.
        nx_req[1] = 1'b1; nx_addr[1] = 32'h8;
        step_cycle(); chk("d2_grant_c0", 32'(gnt[1]), 32'h0);
        step_cycle(); chk("d2_grant_c1", 32'(gnt[1]), 32'h0);
        step_cycle(); chk("d2_grant_c2", 32'(gnt[1]), 32'h1);
        nx_req[1] = 1'b0;
        step_cycle(); chk("d2_rvalid_c3", 32'(rv[1]), 32'h0);
        step_cycle(); chk("d2_rvalid_c4", 32'(rv[1]), 32'h1);
        chk("d2_rdata", rdata[1], 32'hC0DE0002);
        step_cycle(); chk("d2_outs_c5", 32'(outs1), 32'h0);

        // Reset while a request is in flight.
        nx_req[1] = 1'b1; nx_addr[1] = 32'hC;
        step_cycle(); step_cycle(); step_cycle();
        chk("d5_grant", 32'(gnt[1]), 32'h1);
        nx_req[1] = 1'b0; nx_rst = 1'b0;
        step_cycle();
        chk("d5_outs_rst", 32'(outs1), 32'h0);
        nx_rst = 1'b1;
        step_cycle();
        chk("d5_no_rvalid", 32'(rv[1]), 32'h0);
        chk("d5_outs_after", 32'(outs1), 32'h0);
        nx_req[1] = 1'b1; nx_addr[1] = 32'h14;
        step_cycle(); step_cycle(); step_cycle();
        chk("d5_regrant", 32'(gnt[1]), 32'h1);
        nx_req[1] = 1'b0;
        step_cycle(); step_cycle();
        chk("d5_rvalid", 32'(rv[1]), 32'h1);
        chk("d5_rdata", rdata[1], 32'hC0DE0005);

        // Outstanding limit of 2 with three-cycle return latency.
        ng = 0;
        for (int k = 0; k < 7; k++) begin
            nx_req[2]  = (ng < 3);
            nx_addr[2] = 32'(ng * 4);
            step_cycle();
            chk($sformatf("d3_grant_c%0d", k), 32'(gnt[2]), 32'(d3_g[k]));
            chk($sformatf("d3_rvalid_c%0d", k), 32'(rv[2]), 32'(d3_v[k]));
            chk($sformatf("d3_outs_c%0d", k), 32'(outs2), 32'(d3_o[k]));
            chk($sformatf("d3_rdata_c%0d", k), rdata[2], d3_dat[k]);
            if (gnt[2]) ng++;
        end
        nx_req[2] = 1'b0;
        step_cycle();

        // Request withdrawn before grant.
        nx_req[1] = 1'b1; nx_addr[1] = 32'h0;
        step_cycle(); chk("d6_grant_c0", 32'(gnt[1]), 32'h0);
        step_cycle(); chk("d6_grant_c1", 32'(gnt[1]), 32'h0);
        nx_req[1] = 1'b0;
        step_cycle(); chk("d6_grant_c2", 32'(gnt[1]), 32'h0);
        step_cycle(); chk("d6_perr_set", 32'(perr[1]), 32'h1);
        nx_req[1] = 1'b1; nx_addr[1] = 32'h4;
        step_cycle(); step_cycle(); step_cycle();
        nx_req[1] = 1'b0;
        step_cycle(); step_cycle();
        chk("d6_perr_sticky", 32'(perr[1]), 32'h1);
        nx_rst = 1'b0;
        step_cycle();
        chk("d6_perr_cleared", 32'(perr[1]), 32'h0);
        nx_rst = 1'b1;

        // Random traffic.
        for (int t = 0; t < 4000; t++) begin
            nx_rst = ($urandom_range(0, 399) != 0);
            for (int i = 0; i < N; i++) begin
                if (!(req[i] && !m_gnt[i])) begin
                    nx_req[i] = ($urandom_range(0, 99) < 55);
                    if ($urandom_range(0, 9) == 0) nx_addr[i] = $urandom;
                    else nx_addr[i] = 32'($urandom_range(0, DEPTH * 4 - 1));
                end
                nx_stall[i] = ($urandom_range(0, 99) < 15);
            end
            nx_load_en   = ($urandom_range(0, 3) == 0);
            nx_load_addr = 32'($urandom_range(0, DEPTH + 100));
            nx_load_data = $urandom;
            step_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
